// File: rtl/cpu_boot_ctrl.sv
// rtl/cpu_boot_ctrl.sv - boot sequencer: load imem, run the CPU for a budget, dump a dmem window.
// Optional CPU_BOOT_CTRL_CYCLE_CNT_EN adds the cycles_run output.
module cpu_boot_ctrl #(
  parameter int IMEM_ADDR_W = 9,
  parameter int DMEM_ADDR_W = 10,
  parameter int DATA_W      = 32,
  parameter int CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [IMEM_ADDR_W:0]   prog_len,
  input  logic [CNT_W-1:0]       run_cycles,
  input  logic [31:0]            dump_base,
  input  logic [DMEM_ADDR_W:0]   dump_len,
  input  logic                   prog_valid,
  input  logic [DATA_W-1:0]      prog_data,
  output logic                   prog_ready,
  output logic [31:0]            imem_addr_ext,
  output logic                   imem_wen_ext,
  output logic                   imem_ren_ext,
  output logic [DATA_W-1:0]      imem_wdata_ext,
  output logic [31:0]            dmem_addr_ext,
  output logic                   dmem_wen_ext,
  output logic                   dmem_ren_ext,
  input  logic [DATA_W-1:0]      dmem_rdata_ext,
  output logic                   cpu_enable,
  output logic                   cpu_arst_n,
  input  logic                   halt,
  output logic                   dump_valid,
  output logic [DATA_W-1:0]      dump_data,
  input  logic                   dump_ready,
  output logic                   busy,
  output logic                   done,
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
  output logic [CNT_W-1:0]       cycles_run,
`endif
  output logic [2:0]             state
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LOAD       = 3'd1,
    S_LOAD_FLUSH = 3'd2,
    S_RUN        = 3'd3,
    S_DUMP_RD    = 3'd4,
    S_DUMP_CAP   = 3'd5,
    S_DUMP_OUT   = 3'd6,
    S_DONE       = 3'd7
  } state_t;

  state_t                 st;
  logic [IMEM_ADDR_W:0]   idx;
  logic [CNT_W-1:0]       run_cnt;
  logic [DMEM_ADDR_W:0]   k;
  logic [IMEM_ADDR_W:0]   prog_len_q;
  logic [CNT_W-1:0]       run_cycles_q;
  logic [31:0]            dump_base_q;
  logic [DMEM_ADDR_W:0]   dump_len_q;

  assign state        = st;
  assign busy         = (st != S_IDLE) && (st != S_DONE);
  assign done         = (st == S_DONE);
  assign imem_ren_ext = 1'b0;
  assign dmem_wen_ext = 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      st             <= S_IDLE;
      idx            <= '0;
      run_cnt        <= '0;
      k              <= '0;
      prog_len_q     <= '0;
      run_cycles_q   <= '0;
      dump_base_q    <= '0;
      dump_len_q     <= '0;
      prog_ready     <= 1'b0;
      imem_wen_ext   <= 1'b0;
      imem_addr_ext  <= '0;
      imem_wdata_ext <= '0;
      dmem_ren_ext   <= 1'b0;
      dmem_addr_ext  <= '0;
      cpu_enable     <= 1'b0;
      cpu_arst_n     <= 1'b0;
      dump_valid     <= 1'b0;
      dump_data      <= '0;
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
      cycles_run     <= '0;
`endif
    end else begin
      imem_wen_ext <= 1'b0;
      dmem_ren_ext <= 1'b0;
      case (st)
        S_IDLE, S_DONE: begin
          cpu_arst_n <= 1'b1;
          if (start) begin
            prog_len_q   <= prog_len;
            run_cycles_q <= run_cycles;
            dump_base_q  <= dump_base;
            dump_len_q   <= dump_len;
            idx          <= '0;
            run_cnt      <= '0;
            k            <= '0;
            prog_ready   <= (prog_len != '0);
            cpu_arst_n   <= 1'b0;
            st           <= S_LOAD;
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
            cycles_run   <= '0;
`endif
          end
        end
        S_LOAD: begin
          if (prog_len_q == '0) begin
            prog_ready <= 1'b0;
            st         <= S_LOAD_FLUSH;
          end else if (prog_valid && prog_ready) begin
            imem_wen_ext   <= 1'b1;
            imem_addr_ext  <= 32'({idx, 2'b00});
            imem_wdata_ext <= prog_data;
            idx            <= idx + 1'b1;
            if ((idx + 1'b1) == prog_len_q) begin
              prog_ready <= 1'b0;
              st         <= S_LOAD_FLUSH;
            end
          end
        end
        S_LOAD_FLUSH: begin
          cpu_arst_n <= 1'b1;
          if (run_cycles_q != '0) begin
            cpu_enable <= 1'b1;
            st         <= S_RUN;
          end else if (dump_len_q != '0) begin
            dmem_ren_ext  <= 1'b1;
            dmem_addr_ext <= dump_base_q;
            st            <= S_DUMP_RD;
          end else begin
            st <= S_DONE;
          end
        end
        S_RUN: begin
          run_cnt <= run_cnt + 1'b1;
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
          cycles_run <= cycles_run + 1'b1;
`endif
          // the cycle that sees halt or exhausts the budget still ran enabled
          if (halt || ((run_cnt + 1'b1) == run_cycles_q)) begin
            cpu_enable <= 1'b0;
            if (dump_len_q != '0) begin
              dmem_ren_ext  <= 1'b1;
              dmem_addr_ext <= dump_base_q;
              st            <= S_DUMP_RD;
            end else begin
              st <= S_DONE;
            end
          end
        end
        S_DUMP_RD: begin
          st <= S_DUMP_CAP;
        end
        S_DUMP_CAP: begin
          dump_data  <= dmem_rdata_ext;
          dump_valid <= 1'b1;
          st         <= S_DUMP_OUT;
        end
        S_DUMP_OUT: begin
          if (dump_ready) begin
            dump_valid <= 1'b0;
            k          <= k + 1'b1;
            if ((k + 1'b1) == dump_len_q) begin
              st <= S_DONE;
            end else begin
              dmem_ren_ext  <= 1'b1;
              dmem_addr_ext <= dump_base_q + 32'({k + 1'b1, 2'b00});
              st            <= S_DUMP_RD;
            end
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_boot_ctrl.sv
// tb/tb_cpu_boot_ctrl.sv - directed self-checking bench for cpu_boot_ctrl.
module tb_cpu_boot_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [9:0]  prog_len;
  logic [31:0] run_cycles;
  logic [31:0] dump_base;
  logic [10:0] dump_len;
  logic        prog_valid;
  logic [31:0] prog_data;
  logic        prog_ready;
  logic [31:0] imem_addr_ext;
  logic        imem_wen_ext;
  logic        imem_ren_ext;
  logic [31:0] imem_wdata_ext;
  logic [31:0] dmem_addr_ext;
  logic        dmem_wen_ext;
  logic        dmem_ren_ext;
  logic [31:0] dmem_rdata_ext = 32'h0;
  logic        cpu_enable;
  logic        cpu_arst_n;
  logic        halt;
  logic        dump_valid;
  logic [31:0] dump_data;
  logic        dump_ready;
  logic        busy;
  logic        done;
  logic [2:0]  state;
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
  logic [31:0] cycles_run;
`endif

  cpu_boot_ctrl dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .run_cycles(run_cycles), .dump_base(dump_base), .dump_len(dump_len),
    .prog_valid(prog_valid), .prog_data(prog_data), .prog_ready(prog_ready),
    .imem_addr_ext(imem_addr_ext), .imem_wen_ext(imem_wen_ext),
    .imem_ren_ext(imem_ren_ext), .imem_wdata_ext(imem_wdata_ext),
    .dmem_addr_ext(dmem_addr_ext), .dmem_wen_ext(dmem_wen_ext),
    .dmem_ren_ext(dmem_ren_ext), .dmem_rdata_ext(dmem_rdata_ext),
    .cpu_enable(cpu_enable), .cpu_arst_n(cpu_arst_n), .halt(halt),
    .dump_valid(dump_valid), .dump_data(dump_data), .dump_ready(dump_ready),
    .busy(busy), .done(done),
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
    .cycles_run(cycles_run),
`endif
    .state(state)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  logic [31:0] wa[$];
  logic [31:0] wd[$];
  logic [31:0] ra[$];
  logic [31:0] words[3];

  // instruction-write log and a one-cycle-latency data memory
  always @(posedge clk) begin
    if (imem_wen_ext) begin
      wa.push_back(imem_addr_ext);
      wd.push_back(imem_wdata_ext);
    end
    if (dmem_ren_ext) begin
      ra.push_back(dmem_addr_ext);
      dmem_rdata_ext <= (dmem_addr_ext == 32'h10) ? 32'hAAAA0001 :
                        (dmem_addr_ext == 32'h14) ? 32'hBBBB0002 : 32'hDEADBEEF;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    int en;
    int b;
    logic acc;
    words[0] = 32'h20010005;
    words[1] = 32'h20020007;
    words[2] = 32'h00221820;
    rst = 1'b1; start = 1'b0; prog_len = '0; run_cycles = '0; dump_base = '0;
    dump_len = '0; prog_valid = 1'b0; prog_data = '0; halt = 1'b0; dump_ready = 1'b0;

    // reset state
    tick(); tick();
    check("rst_state", 32'(state), 32'd0);
    check("rst_cpu_enable", 32'(cpu_enable), 32'd0);
    check("rst_cpu_arst_n", 32'(cpu_arst_n), 32'd0);
    check("rst_prog_ready", 32'(prog_ready), 32'd0);
    check("rst_dump_valid", 32'(dump_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_imem_addr", imem_addr_ext, 32'd0);
    check("tied_imem_ren", 32'(imem_ren_ext), 32'd0);
    check("tied_dmem_wen", 32'(dmem_wen_ext), 32'd0);
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
    check("rst_cycles_run", cycles_run, 32'd0);
`endif
    rst = 1'b0;
    tick();
    check("idle_cpu_arst_n", 32'(cpu_arst_n), 32'd1);

    // continuous load of 3 words, 10-cycle run, 2-word dump with stall
    start = 1'b1; prog_len = 10'd3; run_cycles = 32'd10; dump_base = 32'h10; dump_len = 11'd2;
    prog_valid = 1'b1;
    tick();
    start = 1'b0;
    check("load_state", 32'(state), 32'd1);
    for (int i = 0; i < 3; i++) begin
      prog_data = words[i];
      check("load_arst_n", 32'(cpu_arst_n), 32'd0);
      check("load_prog_ready", 32'(prog_ready), 32'd1);
      check("load_busy", 32'(busy), 32'd1);
      tick();
    end
    prog_valid = 1'b0;
    check("flush_state", 32'(state), 32'd2);
    check("flush_prog_ready", 32'(prog_ready), 32'd0);
    check("flush_arst_n", 32'(cpu_arst_n), 32'd0);
    check("flush_wen", 32'(imem_wen_ext), 32'd1);
    tick();
    check("t1_write_count", 32'(wa.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t1_write_addr", (i < wa.size()) ? wa[i] : 32'hFFFFFFFF, 32'(i * 4));
      check("t1_write_data", (i < wd.size()) ? wd[i] : 32'hFFFFFFFF, words[i]);
    end
    en = 0;
    for (int c = 0; c < 200 && state == 3'd3; c++) begin
      if (cpu_enable) en++;
      check("run_arst_n", 32'(cpu_arst_n), 32'd1);
      tick();
    end
    check("t3_enable_cycles", 32'(en), 32'd10);
    check("t3_after_run_state", 32'(state), 32'd4);
    check("t3_after_run_enable", 32'(cpu_enable), 32'd0);
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
    check("t3_cycles_run", cycles_run, 32'd10);
`endif
    check("t5_ren0", 32'(dmem_ren_ext), 32'd1);
    check("t5_addr0", dmem_addr_ext, 32'h10);
    tick();
    check("t5_cap_state", 32'(state), 32'd5);
    check("t5_ren_pulse", 32'(dmem_ren_ext), 32'd0);
    tick();
    for (int i = 0; i < 3; i++) begin
      check("t5_stall_valid", 32'(dump_valid), 32'd1);
      check("t5_stall_data", dump_data, 32'hAAAA0001);
      tick();
    end
    dump_ready = 1'b1;
    check("t5_word0_data", dump_data, 32'hAAAA0001);
    tick();
    check("t5_rd1_state", 32'(state), 32'd4);
    check("t5_addr1", dmem_addr_ext, 32'h14);
    check("t5_valid_drop", 32'(dump_valid), 32'd0);
    tick(); tick();
    check("t5_word1_valid", 32'(dump_valid), 32'd1);
    check("t5_word1_data", dump_data, 32'hBBBB0002);
    tick();
    dump_ready = 1'b0;
    check("t5_done", 32'(done), 32'd1);
    check("t5_done_state", 32'(state), 32'd7);
    check("t5_done_busy", 32'(busy), 32'd0);
    check("t5_read_count", 32'(ra.size()), 32'd2);
    tick();
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
    check("t5_cycles_run_hold", cycles_run, 32'd10);
`endif

    // gapped load, then halt in RUN cycle 5 with no dump
    wa.delete(); wd.delete();
    start = 1'b1; prog_len = 10'd3; run_cycles = 32'd100; dump_len = 11'd0;
    tick();
    start = 1'b0;
    b = 0;
    for (int c = 0; c < 30 && state == 3'd1; c++) begin
      prog_valid = c[0];
      prog_data = words[(b < 3) ? b : 0];
      acc = prog_valid && prog_ready;
      tick();
      if (acc) b++;
    end
    prog_valid = 1'b0;
    check("t2_beats", 32'(b), 32'd3);
    check("t2_flush_state", 32'(state), 32'd2);
    tick();
    en = 0;
    for (int c = 1; c <= 200 && state == 3'd3; c++) begin
      halt = (c == 5);
      if (cpu_enable) en++;
      tick();
    end
    halt = 1'b0;
    check("t4_enable_cycles", 32'(en), 32'd5);
    check("t4_enable_low", 32'(cpu_enable), 32'd0);
    check("t4_state_done", 32'(state), 32'd7);
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
    check("t4_cycles_run", cycles_run, 32'd5);
`endif
    check("t2_write_count", 32'(wa.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      check("t2_write_addr", (i < wa.size()) ? wa[i] : 32'hFFFFFFFF, 32'(i * 4));
      check("t2_write_data", (i < wd.size()) ? wd[i] : 32'hFFFFFFFF, words[i]);
    end

    // reset in RUN cycle 3, then an empty sequence
    start = 1'b1; prog_len = 10'd0; run_cycles = 32'd100; dump_len = 11'd0;
    tick();
    start = 1'b0;
    tick(); tick();
    check("t6_run1", 32'(state), 32'd3);
    tick(); tick();
    check("t6_run3_enable", 32'(cpu_enable), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_enable", 32'(cpu_enable), 32'd0);
    check("t6_rst_arst_n", 32'(cpu_arst_n), 32'd0);
    check("t6_rst_state", 32'(state), 32'd0);
    tick();
    wa.delete(); wd.delete();
    start = 1'b1; prog_len = 10'd0; run_cycles = 32'd0; dump_len = 11'd0;
    prog_valid = 1'b1; prog_data = 32'h12345678;
    tick();
    start = 1'b0;
    check("t6_load", 32'(state), 32'd1);
    check("t6_load_ready", 32'(prog_ready), 32'd0);
    tick();
    check("t6_flush", 32'(state), 32'd2);
    tick();
    prog_valid = 1'b0;
    check("t6_done_state", 32'(state), 32'd7);
    check("t6_done", 32'(done), 32'd1);
`ifdef CPU_BOOT_CTRL_CYCLE_CNT_EN
    check("t6_cycles_run", cycles_run, 32'd0);
`endif
    tick();
    check("t6_no_writes", 32'(wa.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
